piso_bit_serializer: RTL and testbench

- Upstream feeder for the single-bit sequence-detector FSM.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a serial line (x_out) qualified by x_valid.
- Optional inter-word idle gap; optional trailing even-parity bit.
- Lets the detector be driven from a word-oriented source instead of hand-toggled stimulus.

---
 rtl/piso_bit_serializer.sv | 129 ++++++++++++
 tb/tb_piso_bit_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out feeder for the sequence detector: valid/ready word capture, MSB-first bit stream.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_bit_serializer #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = 4;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam bit B2B = (GAP_CYCLES == 0);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
   logic par;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic [GW-1:0]    gap_cnt;

   // Back-to-back capture is only offered on the word's final serial cycle when no gap follows.
   always_comb begin
      din_ready = 1'b0;
      case (state)
         IDLE:    din_ready = 1'b1;
`ifdef PISO_PARITY_EN
         PARITY:  din_ready = B2B;
`else
         SHIFT:   din_ready = B2B && (cnt == LAST);
`endif
         default: din_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sreg    <= '0;
         cnt     <= '0;
         gap_cnt <= '0;
         x_out   <= 1'b0;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef PISO_PARITY_EN
         par     <= 1'b0;
`endif
      end else if (din_valid && din_ready) begin
         state   <= SHIFT;
         sreg    <= din;
         cnt     <= '0;
         x_out   <= din[WIDTH-1];
         x_valid <= 1'b1;
         busy    <= 1'b1;
         done    <= 1'b0;
`ifdef PISO_PARITY_EN
         par     <= ^din;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
                  state <= PARITY;
                  x_out <= par;
                  done  <= 1'b1;
`else
                  x_out   <= 1'b0;
                  x_valid <= 1'b0;
                  done    <= 1'b0;
                  gap_cnt <= '0;
                  if (GAP_CYCLES > 0) begin
                     state <= GAP;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
`endif
               end else begin
                  sreg  <= {sreg[WIDTH-2:0], 1'b0};
                  x_out <= sreg[WIDTH-2];
                  cnt   <= cnt + 1'b1;
`ifdef PISO_PARITY_EN
                  done  <= 1'b0;
`else
                  done  <= (cnt == LAST - 1'b1);
`endif
               end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
               x_out   <= 1'b0;
               x_valid <= 1'b0;
               done    <= 1'b0;
               gap_cnt <= '0;
               if (GAP_CYCLES > 0) begin
                  state <= GAP;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
`endif
            GAP: begin
               if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench: one instance with no gap, one with a 2-cycle gap, sharing clock and reset.
module tb_piso_bit_serializer;
`ifdef PISO_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   typedef struct {
      logic [7:0] word;
      logic       par;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din0, din2;
   logic       v0, v2;
   logic       rdy0, xo0, xv0, busy0, done0;
   logic       rdy2, xo2, xv2, busy2, done2;
   int         checks = 0;
   int         errors = 0;
   vec_t       vt[6];

   always #5 clk = ~clk;

   piso_bit_serializer #(.WIDTH(8), .GAP_CYCLES(0)) u0 (
      .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
      .x_out(xo0), .x_valid(xv0), .busy(busy0), .done(done0)
   );

   piso_bit_serializer #(.WIDTH(8), .GAP_CYCLES(2)) u2 (
      .clk(clk), .rst(rst), .din(din2), .din_valid(v2), .din_ready(rdy2),
      .x_out(xo2), .x_valid(xv2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic logic eb(input logic [7:0] w, input logic p, input int i);
      if (i < 8) return w[7-i];
      return p;
   endfunction

   initial begin
      vt[0] = '{8'hA5, 1'b0};
      vt[1] = '{8'h3C, 1'b0};
      vt[2] = '{8'h00, 1'b0};
      vt[3] = '{8'hFF, 1'b0};
      vt[4] = '{8'h80, 1'b1};
      vt[5] = '{8'h07, 1'b1};

      rst = 1'b0; din0 = '0; din2 = '0; v0 = 1'b0; v2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst x_out",   xo0,   0);
      chk("rst x_valid", xv0,   0);
      chk("rst busy",    busy0, 0);
      chk("rst done",    done0, 0);
      chk("rst ready",   rdy0,  1);
      chk("rst ready2",  rdy2,  1);
      chk("rst busy2",   busy2, 0);
      rst = 1'b1;

      // single words from the table
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         din0 = vt[k].word; v0 = 1'b1;
         @(negedge clk);
         v0 = 1'b0;
         for (int i = 0; i < NB; i++) begin
            chk($sformatf("vec%0d bit%0d x_out", k, i), xo0, eb(vt[k].word, vt[k].par, i));
            chk($sformatf("vec%0d bit%0d x_valid", k, i), xv0, 1);
            chk($sformatf("vec%0d bit%0d done", k, i), done0, (i == NB-1));
            chk($sformatf("vec%0d bit%0d ready", k, i), rdy0, (i == NB-1));
            @(negedge clk);
         end
         chk($sformatf("vec%0d end x_valid", k), xv0, 0);
         chk($sformatf("vec%0d end x_out", k), xo0, 0);
         chk($sformatf("vec%0d end busy", k), busy0, 0);
         chk($sformatf("vec%0d end ready", k), rdy0, 1);
      end

      // back-to-back A5 then 3C with din_valid held high
      @(negedge clk);
      din0 = 8'hA5; v0 = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 2*NB; j++) begin
         if (j == 0) din0 = 8'h3C;
         if (j == NB) v0 = 1'b0;
         chk($sformatf("b2b %0d x_out", j), xo0,
             eb((j < NB) ? 8'hA5 : 8'h3C, 1'b0, j % NB));
         chk($sformatf("b2b %0d x_valid", j), xv0, 1);
         chk($sformatf("b2b %0d done", j), done0, (j == NB-1) || (j == 2*NB-1));
         @(negedge clk);
      end
      chk("b2b end x_valid", xv0, 0);

      // gap instance: second word offered during the gap must wait for IDLE
      @(negedge clk);
      din2 = 8'hA5; v2 = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 2*NB+3; j++) begin
         if (j < NB) begin
            if (j == 0) din2 = 8'hFF;
            chk($sformatf("gap w1 %0d x_out", j), xo2, eb(8'hA5, 1'b0, j));
            chk($sformatf("gap w1 %0d x_valid", j), xv2, 1);
            chk($sformatf("gap w1 %0d ready", j), rdy2, 0);
            chk($sformatf("gap w1 %0d done", j), done2, (j == NB-1));
         end else if (j < NB+2) begin
            chk($sformatf("gap %0d x_valid", j), xv2, 0);
            chk($sformatf("gap %0d x_out", j), xo2, 0);
            chk($sformatf("gap %0d busy", j), busy2, 1);
            chk($sformatf("gap %0d ready", j), rdy2, 0);
         end else if (j == NB+2) begin
            chk("gap idle x_valid", xv2, 0);
            chk("gap idle busy", busy2, 0);
            chk("gap idle ready", rdy2, 1);
            din2 = 8'h3C;
         end else begin
            if (j == NB+3) v2 = 1'b0;
            chk($sformatf("gap w2 %0d x_out", j), xo2, eb(8'h3C, 1'b0, j-NB-3));
            chk($sformatf("gap w2 %0d x_valid", j), xv2, 1);
            chk($sformatf("gap w2 %0d done", j), done2, (j == 2*NB+2));
         end
         @(negedge clk);
      end
      chk("gap end x_valid", xv2, 0);

      // asynchronous reset in the middle of a word
      @(negedge clk);
      din0 = 8'hFF; v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("abort bit%0d x_out", i), xo0, 1);
         chk($sformatf("abort bit%0d x_valid", i), xv0, 1);
         if (i < 2) @(negedge clk);
      end
      #2 rst = 1'b0;
      #1;
      chk("abort x_out",   xo0,   0);
      chk("abort x_valid", xv0,   0);
      chk("abort busy",    busy0, 0);
      chk("abort done",    done0, 0);
      chk("abort ready",   rdy0,  1);
      @(negedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("post-abort %0d x_valid", i), xv0, 0);
         chk($sformatf("post-abort %0d busy", i), busy0, 0);
      end
      chk("post-abort ready", rdy0, 1);

      // a fresh word after the abort starts cleanly from its MSB
      din0 = 8'h80; v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      chk("restart bit0 x_out", xo0, 1);
      chk("restart bit0 x_valid", xv0, 1);
      @(negedge clk);
      chk("restart bit1 x_out", xo0, 0);
      repeat (NB) @(negedge clk);
      chk("restart end x_valid", xv0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
